// File: rtl/pipe_decode_pkg.sv
// Shared types and default sizing for the decode stage and its register file.
package pipe_decode_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NREGS     = 8;
  localparam int DEF_SIG_W     = 41;
  localparam int DEF_INSEL_BIT = 18;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_decode_if.sv
// Fetch-side inputs, write-back port and ID/EX outputs of the decode stage.
interface pipe_decode_if
  import pipe_decode_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_NREGS),
  parameter int SIG_W  = DEF_SIG_W
);

  logic              in_valid;
  logic              imm_flag;
  logic [SIG_W-1:0]  signals_in;
  logic [ADDR_W-1:0] rsrc1;
  logic [ADDR_W-1:0] rsrc2;
  logic [ADDR_W-1:0] rdst;
  logic [DATA_W-1:0] instr_word;
  logic [DATA_W-1:0] in_port;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              flush;

  logic              out_valid;
  logic [SIG_W-1:0]  signals_out;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] imm_out;
  logic [ADDR_W-1:0] rdst_out;
  logic              busy;

  modport master (
    output in_valid, imm_flag, signals_in, rsrc1, rsrc2, rdst, instr_word,
           in_port, wb_en, wb_addr, wb_data, stall, flush,
    input  out_valid, signals_out, read_data1, read_data2, imm_out,
           rdst_out, busy
  );

  modport slave (
    input  in_valid, imm_flag, signals_in, rsrc1, rsrc2, rdst, instr_word,
           in_port, wb_en, wb_addr, wb_data, stall, flush,
    output out_valid, signals_out, read_data1, read_data2, imm_out,
           rdst_out, busy
  );

endinterface

// File: rtl/pipe_regfile.sv
// General-purpose register file: one write port, two write-through read ports.
module pipe_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // A write landing this cycle is visible to readers in the same cycle.
  assign rdata1 = (wb_en && (wb_addr == raddr1)) ? wb_data : regs[raddr1];
  assign rdata2 = (wb_en && (wb_addr == raddr2)) ? wb_data : regs[raddr2];

endmodule

// File: rtl/pipe_decode.sv
// Instruction decode stage: operand fetch, immediate-word pairing and the ID/EX register.
module pipe_decode
  import pipe_decode_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NREGS     = DEF_NREGS,
  parameter int ADDR_W    = $clog2(NREGS),
  parameter int SIG_W     = DEF_SIG_W,
  parameter int INSEL_BIT = DEF_INSEL_BIT
) (
  input logic          clk,
  input logic          rst,
  pipe_decode_if.slave bus
);

  state_t state, next_state;

  logic [DATA_W-1:0] rf_rd1, rf_rd2, op1, hop1, hop2;
  logic              snoop1, snoop2;

  logic              valid_q, n_valid;
  logic [SIG_W-1:0]  sig_q, n_sig;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q, n_rd1, n_rd2, n_imm;
  logic [ADDR_W-1:0] rdst_q, n_rdst;

  logic [SIG_W-1:0]  hsig_q, n_hsig;
  logic [ADDR_W-1:0] hsrc1_q, hsrc2_q, hrdst_q, n_hsrc1, n_hsrc2, n_hrdst;
  logic [DATA_W-1:0] hop1_q, hop2_q, n_hop1, n_hop2;

  pipe_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wb_en  (bus.wb_en),
    .wb_addr(bus.wb_addr),
    .wb_data(bus.wb_data),
    .raddr1 (bus.rsrc1),
    .raddr2 (bus.rsrc2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // Held operands track write-backs to their source registers while the
  // immediate word is outstanding, so the paired instruction never sees stale data.
  always_comb begin
    op1    = bus.signals_in[INSEL_BIT] ? bus.in_port : rf_rd1;
    snoop1 = (state == WAIT_IMM) && bus.wb_en && !hsig_q[INSEL_BIT] &&
             (bus.wb_addr == hsrc1_q);
    snoop2 = (state == WAIT_IMM) && bus.wb_en && (bus.wb_addr == hsrc2_q);
    hop1   = snoop1 ? bus.wb_data : hop1_q;
    hop2   = snoop2 ? bus.wb_data : hop2_q;
  end

  always_comb begin
    next_state = state;
    n_valid    = 1'b0;
    n_sig      = '0;
    n_rd1      = '0;
    n_rd2      = '0;
    n_imm      = '0;
    n_rdst     = '0;
    n_hsig     = hsig_q;
    n_hsrc1    = hsrc1_q;
    n_hsrc2    = hsrc2_q;
    n_hrdst    = hrdst_q;
    n_hop1     = hop1;
    n_hop2     = hop2;

    if (bus.flush) begin
      next_state = IDLE;
      n_hsig     = '0;
      n_hsrc1    = '0;
      n_hsrc2    = '0;
      n_hrdst    = '0;
      n_hop1     = '0;
      n_hop2     = '0;
    end else if (bus.stall) begin
      n_valid = valid_q;
      n_sig   = sig_q;
      n_rd1   = rd1_q;
      n_rd2   = rd2_q;
      n_imm   = imm_q;
      n_rdst  = rdst_q;
    end else if (bus.in_valid) begin
      case (state)
        IDLE: begin
          if (bus.imm_flag) begin
            n_hsig     = bus.signals_in;
            n_hsrc1    = bus.rsrc1;
            n_hsrc2    = bus.rsrc2;
            n_hrdst    = bus.rdst;
            n_hop1     = op1;
            n_hop2     = rf_rd2;
            next_state = WAIT_IMM;
          end else begin
            n_valid = 1'b1;
            n_sig   = bus.signals_in;
            n_rd1   = op1;
            n_rd2   = rf_rd2;
            n_rdst  = bus.rdst;
          end
        end
        WAIT_IMM: begin
          n_valid    = 1'b1;
          n_sig      = hsig_q;
          n_rd1      = hop1;
          n_rd2      = hop2;
          n_imm      = bus.instr_word;
          n_rdst     = hrdst_q;
          next_state = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      sig_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rdst_q  <= '0;
      hsig_q  <= '0;
      hsrc1_q <= '0;
      hsrc2_q <= '0;
      hrdst_q <= '0;
      hop1_q  <= '0;
      hop2_q  <= '0;
    end else begin
      state   <= next_state;
      valid_q <= n_valid;
      sig_q   <= n_sig;
      rd1_q   <= n_rd1;
      rd2_q   <= n_rd2;
      imm_q   <= n_imm;
      rdst_q  <= n_rdst;
      hsig_q  <= n_hsig;
      hsrc1_q <= n_hsrc1;
      hsrc2_q <= n_hsrc2;
      hrdst_q <= n_hrdst;
      hop1_q  <= n_hop1;
      hop2_q  <= n_hop2;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.signals_out = sig_q;
  assign bus.read_data1  = rd1_q;
  assign bus.read_data2  = rd2_q;
  assign bus.imm_out     = imm_q;
  assign bus.rdst_out    = rdst_q;
  assign bus.busy        = (state == WAIT_IMM);

endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, operand/register width; NREGS, 8, register count (power of two, >=2); ADDR_W, clog2(NREGS), register address width; SIG_W, 41, control-signal vector width; INSEL_BIT, 18, index of the input-port-select bit in the signal vector.
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  fetched word valid this cycle; imm_flag  in  1  current instruction needs a following immediate word.
REQ-004 signals_in  in  SIG_W  control vector from control unit; rsrc1, rsrc2, rdst  in  ADDR_W  register fields; instr_word  in  DATA_W  raw fetched word.
REQ-005 in_port  in  DATA_W  external input port; wb_en  in  1, wb_addr  in  ADDR_W, wb_data  in  DATA_W  write-back port.
REQ-006 stall  in  1  hold stage; flush  in  1  kill stage contents.
REQ-007 out_valid  out  1; signals_out  out  SIG_W; read_data1, read_data2, imm_out  out  DATA_W; rdst_out  out  ADDR_W; busy  out  1  high in WAIT_IMM (registered ID/EX outputs).

Function
REQ-008 Register file SHALL hold NREGS x DATA_W, written at rising clk when wb_en, address wb_addr; no hard-wired register.
REQ-009 Register reads SHALL be combinational with write-through bypass: if wb_en and wb_addr equals the read address, wb_data is returned.
REQ-010 Operand 1 SHALL be in_port when signals_in[INSEL_BIT]=1, else bypassed register rsrc1; operand 2 always bypassed register rsrc2.
REQ-011 FSM states SHALL be IDLE and WAIT_IMM; busy = (state == WAIT_IMM).
REQ-012 IDLE, in_valid=1, imm_flag=0, no stall/flush: next cycle out_valid=1, signals_out/read_data1/read_data2/rdst_out from current inputs, imm_out=0 (latency 1 cycle).
REQ-013 IDLE, in_valid=1, imm_flag=1: signals, operands, rdst latched into hold registers; ID/EX emits bubble (out_valid=0, signals_out=0); next state WAIT_IMM.
REQ-014 WAIT_IMM: while wb_en hits a held source register (rsrc1 when INSEL=0, rsrc2), held operand SHALL be updated with wb_data.
REQ-015 WAIT_IMM, in_valid=1: next cycle emits held instruction with imm_out=instr_word, out_valid=1; next state IDLE; imm_flag ignored in this cycle.
REQ-016 in_valid=0 (either state, no stall): ID/EX emits bubble; FSM holds state.
REQ-017 stall=1, flush=0: ID/EX outputs, FSM state and hold registers unchanged; register-file write and REQ-014 snooping still occur.
REQ-018 flush=1 (overrides stall): next cycle out_valid=0, signals_out=0, data outputs 0, state IDLE, hold registers discarded; register-file write still occurs.
REQ-019 Bubble SHALL zero read_data1/2, imm_out, rdst_out as well as signals_out.

Reset
REQ-020 rst=0 SHALL immediately force state IDLE, all outputs 0, hold registers 0, all register-file entries 0, independent of clk.
REQ-021 Reset mid-WAIT_IMM SHALL discard the pending instruction; first valid fetch after release is decoded from IDLE.

Structure
REQ-022 Package pipe_decode_pkg SHALL hold the FSM state enum and default values of DATA_W, NREGS, SIG_W, INSEL_BIT.
REQ-023 Register file SHALL be sub-module pipe_regfile (parametrised DATA_W/NREGS, one write and two bypassed read ports, async-low reset).

Verification
REQ-024 Reset, then wb R3=0x1234 at cycle 1; cycle 2 in_valid, rsrc1=3, imm_flag=0 -> cycle 3 read_data1=0x1234, out_valid=1, imm_out=0.
REQ-025 Same cycle wb_en R5=0xBEEF and read rsrc2=5 -> next cycle read_data2=0xBEEF (bypass).
REQ-026 signals_in[18]=1, in_port=0x00A5, R1=0x1111, rsrc1=1 -> read_data1=0x00A5.
REQ-027 imm_flag=1 instruction, then stall 2 cycles with wb R2=0x7777 (rsrc2=2), then instr_word=0x0042 -> busy high 3 cycles, single out_valid pulse, imm_out=0x0042, read_data2=0x7777.
REQ-028 flush asserted together with stall during WAIT_IMM -> next cycle out_valid=0, busy=0, signals_out=0; following non-imm instruction decodes normally.
REQ-029 rst pulled low mid-WAIT_IMM between clock edges -> outputs 0 immediately, all registers read 0 afterwards.
